pe_state_sequencer: RTL and testbench

- Transmit end of the PE state distribution path in the weight-buffer controller.
- Generates the per-tile PE_STATE command stream (clear, weight load, compute, accumulate-out) with valid/ready pacing against the weight buffer and activation feed.
- Drives the head of the per-row state delay chains, which skew it across the PE array.
- Reports busy and done once the last command has cleared the deepest delay chain.

---
 rtl/pe_state_sequencer_pkg.sv | 39 +++
 rtl/pe_state_sequencer_if.sv | 28 ++
 rtl/pe_state_sequencer_beat_counter.sv | 29 ++
 rtl/pe_state_sequencer.sv | 172 +++++++++++++++++
 tb/tb_pe_state_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_state_sequencer_pkg.sv
// Shared definitions for the weight-buffer controller PE state path:
// command encoding, sequencer states and the delay-chain depth.
package pe_state_sequencer_pkg;

`ifndef SD
`define SD
`endif

    typedef enum logic [7:0] {
        PE_VALID   = 8'h00,
        PE_CLEAR   = 8'h01,
        PE_LOAD_W  = 8'h02,
        PE_COMPUTE = 8'h04,
        PE_ACC_OUT = 8'h08
    } pe_state_e;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE    = 3'd0;
    localparam seq_state_t ST_CLEAR   = 3'd1;
    localparam seq_state_t ST_LOAD    = 3'd2;
    localparam seq_state_t ST_COMPUTE = 3'd3;
    localparam seq_state_t ST_ACCOUT  = 3'd4;
    localparam seq_state_t ST_DRAIN   = 3'd5;

    localparam int PE_ROWS_DEFAULT = 3;

    // First work phase still owed by the tile; ACC_OUT when nothing is left.
    function automatic seq_state_t work_state(input logic load_pending, input logic comp_pending);
        if (load_pending) begin
            return ST_LOAD;
        end else if (comp_pending) begin
            return ST_COMPUTE;
        end else begin
            return ST_ACCOUT;
        end
    endfunction

endpackage

// File: rtl/pe_state_sequencer_if.sv
// Handshake and command bundle between the tile controller and the PE state sequencer.
interface pe_state_sequencer_if
    import pe_state_sequencer_pkg::*;
#(
    parameter int LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] cfg_load_len;
    logic [LEN_W-1:0] cfg_comp_len;
    logic             abort;
    logic             wb_valid;
    logic             wb_ready;
    logic             act_valid;
    logic             act_ready;
    pe_state_e        state_out;
    logic             busy;
    logic             done;

    modport master (
        output start, cfg_load_len, cfg_comp_len, abort, wb_valid, act_valid,
        input  wb_ready, act_ready, state_out, busy, done
    );

    modport slave (
        input  start, cfg_load_len, cfg_comp_len, abort, wb_valid, act_valid,
        output wb_ready, act_ready, state_out, busy, done
    );
endinterface

// File: rtl/pe_state_sequencer_beat_counter.sv
// Up-counter of accepted words/beats; flags the final one (count == len-1)
// and returns to zero as that final beat is taken, so it never wraps.
module pe_state_sequencer_beat_counter #(
    parameter int LEN_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [LEN_W-1:0] len,
    output logic             last
);
    logic [LEN_W-1:0] count_r;

    assign last = (count_r == (len - LEN_W'(1)));

    // Beat count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= {LEN_W{1'b0}};
        end else if (clear || (enable && last)) begin
            count_r <= {LEN_W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + LEN_W'(1);
        end else begin
            count_r <= count_r;
        end
    end
endmodule

// File: rtl/pe_state_sequencer.sv
// PE_STATE command generator: paces clear/load/compute/acc-out against the
// weight buffer and activation feed, then drains the row delay chains.
module pe_state_sequencer
    import pe_state_sequencer_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int PE_ROWS = PE_ROWS_DEFAULT
) (
    input logic                 clock,
    input logic                 reset,
    pe_state_sequencer_if.slave bus
);
    localparam int DRAIN_W = (PE_ROWS > 1) ? $clog2(PE_ROWS) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PE_ROWS - 1);

    seq_state_t       st_r;
    seq_state_t       st_s;
    pe_state_e        cmd_s;
    pe_state_e        state_out_r;
    logic             busy_s;
    logic             busy_r;
    logic             done_s;
    logic             done_r;
    logic [LEN_W-1:0] load_len_r;
    logic [LEN_W-1:0] comp_len_r;
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic             idle_s;
    logic             accept_s;
    logic             comp_nz_s;
    logic             load_nz_s;
    logic             wb_ready_s;
    logic             act_ready_s;
    logic             wb_hs_s;
    logic             act_hs_s;
    logic             load_last_s;
    logic             comp_last_s;
    logic             drain_last_s;

    assign idle_s       = (st_r == ST_IDLE);
    assign accept_s     = idle_s && bus.start;
    assign load_nz_s    = (load_len_r != {LEN_W{1'b0}});
    assign comp_nz_s    = (comp_len_r != {LEN_W{1'b0}});
    // abort must never let a word or beat be consumed, so it gates ready directly
    assign wb_ready_s   = (st_r == ST_LOAD) && !bus.abort;
    assign act_ready_s  = (st_r == ST_COMPUTE) && !bus.abort;
    assign wb_hs_s      = wb_ready_s && bus.wb_valid;
    assign act_hs_s     = act_ready_s && bus.act_valid;
    assign drain_last_s = (drain_cnt_r == DRAIN_LAST);

    assign bus.wb_ready  = wb_ready_s;
    assign bus.act_ready = act_ready_s;
    assign bus.state_out = state_out_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

    pe_state_sequencer_beat_counter #(.LEN_W(LEN_W)) u_load_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (idle_s),
        .enable (wb_hs_s),
        .len    (load_len_r),
        .last   (load_last_s)
    );

    pe_state_sequencer_beat_counter #(.LEN_W(LEN_W)) u_comp_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (idle_s),
        .enable (act_hs_s),
        .len    (comp_len_r),
        .last   (comp_last_s)
    );

    // Next state and the command issued for the following cycle.
    always_comb begin
        st_s   = st_r;
        cmd_s  = PE_VALID;
        busy_s = 1'b1;
        done_s = 1'b0;
        case (st_r)
            ST_IDLE: begin
                if (bus.start) begin
                    st_s  = ST_CLEAR;
                    cmd_s = PE_CLEAR;
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_CLEAR: begin
                st_s = work_state(load_nz_s, comp_nz_s);
            end
            ST_LOAD: begin
                if (bus.abort) begin
                    st_s  = ST_DRAIN;
                    cmd_s = PE_CLEAR;
                end else if (wb_hs_s) begin
                    cmd_s = PE_LOAD_W;
                    st_s  = load_last_s ? work_state(1'b0, comp_nz_s) : ST_LOAD;
                end else begin
                    st_s = ST_LOAD;
                end
            end
            ST_COMPUTE: begin
                if (bus.abort) begin
                    st_s  = ST_DRAIN;
                    cmd_s = PE_CLEAR;
                end else if (act_hs_s) begin
                    cmd_s = PE_COMPUTE;
                    st_s  = comp_last_s ? ST_ACCOUT : ST_COMPUTE;
                end else begin
                    st_s = ST_COMPUTE;
                end
            end
            ST_ACCOUT: begin
                st_s  = ST_DRAIN;
                cmd_s = bus.abort ? PE_CLEAR : PE_ACC_OUT;
            end
            ST_DRAIN: begin
                if (drain_last_s) begin
                    st_s   = ST_IDLE;
                    done_s = 1'b1;
                end else begin
                    st_s = ST_DRAIN;
                end
            end
            default: begin
                st_s   = ST_IDLE;
                busy_s = 1'b0;
            end
        endcase
    end

    // FSM and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_r        <= ST_IDLE;
            state_out_r <= PE_VALID;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            st_r        <= st_s;
            state_out_r <= cmd_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    // Tile lengths, captured only when a start is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_len_r <= {LEN_W{1'b0}};
            comp_len_r <= {LEN_W{1'b0}};
        end else if (accept_s) begin
            load_len_r <= bus.cfg_load_len;
            comp_len_r <= bus.cfg_comp_len;
        end else begin
            load_len_r <= load_len_r;
            comp_len_r <= comp_len_r;
        end
    end

    // Drain cycle counter, idle at zero outside DRAIN.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drain_cnt_r <= {DRAIN_W{1'b0}};
        end else if ((st_r == ST_DRAIN) && !drain_last_s) begin
            drain_cnt_r <= drain_cnt_r + DRAIN_W'(1);
        end else begin
            drain_cnt_r <= {DRAIN_W{1'b0}};
        end
    end
endmodule

// File: tb/tb_pe_state_sequencer.sv
// Bench for pe_state_sequencer: a 16-bit and a 4-bit length instance share stimulus
// and are checked every cycle against a tile-level model, plus directed literal checks.
module tb_pe_state_sequencer;
    import pe_state_sequencer_pkg::*;

    localparam int ROWS = 3;
    localparam int P_IDLE = 0, P_CLEAR = 1, P_LOAD = 2, P_COMP = 3, P_ACC = 4, P_DRAIN = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic st = 1'b0, ab = 1'b0, wv = 1'b0, av = 1'b0;
    logic [3:0] l_len = 4'd0, c_len = 4'd0;

    int total = 0;
    int bad = 0;

    int m_phase, m_load_left, m_comp_left, m_drain_left;
    logic [7:0] m_out;
    logic m_busy, m_done;

    logic [7:0] obs_out [32];
    logic [7:0] obs4_out [32];
    logic obs_busy [32];
    logic obs_done [32];
    logic obs_wbr [32];
    logic obs_actr [32];

    always #5 clock = ~clock;

    pe_state_sequencer_if #(.LEN_W(16)) bus16 ();
    pe_state_sequencer_if #(.LEN_W(4))  bus4 ();

    assign bus16.start = st;   assign bus4.start = st;
    assign bus16.abort = ab;   assign bus4.abort = ab;
    assign bus16.wb_valid = wv;  assign bus4.wb_valid = wv;
    assign bus16.act_valid = av; assign bus4.act_valid = av;
    assign bus16.cfg_load_len = {12'h000, l_len};
    assign bus16.cfg_comp_len = {12'h000, c_len};
    assign bus4.cfg_load_len = l_len;
    assign bus4.cfg_comp_len = c_len;

    pe_state_sequencer #(.LEN_W(16), .PE_ROWS(ROWS)) dut16 (.clock(clock), .reset(reset), .bus(bus16));
    pe_state_sequencer #(.LEN_W(4),  .PE_ROWS(ROWS)) dut4  (.clock(clock), .reset(reset), .bus(bus4));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_load_left = 0; m_comp_left = 0; m_drain_left = 0;
        m_out = 8'h00; m_busy = 1'b0; m_done = 1'b0;
    endtask

    // Tile model: remaining words/beats/drain cycles; m_out is the command seen next cycle.
    task automatic model_step();
        int ph;
        ph = m_phase;
        if (reset) begin
            model_reset();
            return;
        end
        m_busy = (ph != P_IDLE) || st;
        m_done = 1'b0;
        m_out  = 8'h00;
        case (ph)
            P_IDLE: if (st) begin
                m_load_left = int'(l_len); m_comp_left = int'(c_len);
                m_phase = P_CLEAR; m_out = 8'h01;
            end
            P_CLEAR: m_phase = (m_load_left > 0) ? P_LOAD : (m_comp_left > 0) ? P_COMP : P_ACC;
            P_LOAD: if (ab) begin
                m_out = 8'h01; m_phase = P_DRAIN; m_drain_left = ROWS;
            end else if (wv) begin
                m_out = 8'h02; m_load_left--;
                if (m_load_left == 0) m_phase = (m_comp_left > 0) ? P_COMP : P_ACC;
            end
            P_COMP: if (ab) begin
                m_out = 8'h01; m_phase = P_DRAIN; m_drain_left = ROWS;
            end else if (av) begin
                m_out = 8'h04; m_comp_left--;
                if (m_comp_left == 0) m_phase = P_ACC;
            end
            P_ACC: begin
                m_out = ab ? 8'h01 : 8'h08; m_phase = P_DRAIN; m_drain_left = ROWS;
            end
            default: begin
                m_drain_left--;
                if (m_drain_left == 0) begin m_done = 1'b1; m_phase = P_IDLE; end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        model_step();
    endtask

    task automatic quiet(input int n);
        st = 1'b0; ab = 1'b0; wv = 1'b0; av = 1'b0; l_len = 4'd0; c_len = 4'd0;
        repeat (n) tick();
    endtask

    // Cycle-by-cycle compare of both instances against the model.
    always @(negedge clock) begin
        logic [31:0] e;
        e = {20'd0, m_out, m_busy, m_done, (m_phase == P_LOAD) && !ab, (m_phase == P_COMP) && !ab};
        check("dut16_cycle", {20'd0, 8'(bus16.state_out), bus16.busy, bus16.done, bus16.wb_ready, bus16.act_ready}, e);
        check("dut4_cycle",  {20'd0, 8'(bus4.state_out),  bus4.busy,  bus4.done,  bus4.wb_ready,  bus4.act_ready}, e);
    end

    // Cycle k=0 is the start cycle; later cycles carry length 1 to expose stray captures.
    task automatic run_tile(input logic [3:0] ll, input logic [3:0] cl, input int n,
                            input logic [31:0] stp, input logic [31:0] wvp,
                            input logic [31:0] avp, input logic [31:0] abp);
        for (int k = 0; k < n; k++) begin
            st = stp[k]; wv = wvp[k]; av = avp[k]; ab = abp[k];
            l_len = (k == 0) ? ll : 4'd1;
            c_len = (k == 0) ? cl : 4'd1;
            #1;
            obs_out[k] = 8'(bus16.state_out); obs4_out[k] = 8'(bus4.state_out);
            obs_busy[k] = bus16.busy; obs_done[k] = bus16.done;
            obs_wbr[k] = bus16.wb_ready; obs_actr[k] = bus16.act_ready;
            tick();
        end
        quiet(2);
    endtask

    function automatic int count_cmd(input logic [7:0] c, input int n, input logic use4);
        int s = 0;
        for (int k = 0; k < n; k++) s += ((use4 ? obs4_out[k] : obs_out[k]) == c) ? 1 : 0;
        return s;
    endfunction

    function automatic int first_done(input int n);
        for (int k = 0; k < n; k++) if (obs_done[k]) return k;
        return -1;
    endfunction

    initial begin
        logic [7:0] exp1 [14];
        int s;
        exp1 = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h02, 8'h02, 8'h02,
                 8'h04, 8'h04, 8'h04, 8'h08, 8'h00, 8'h00, 8'h00};
        model_reset();
        repeat (2) tick();
        check("reset_state_out", 32'(bus16.state_out), 32'h00);
        check("reset_busy", 32'(bus16.busy), 32'h0);
        check("reset_done", 32'(bus16.done), 32'h0);
        reset = 1'b0;

        // Basic tile without stalls.
        run_tile(4'd4, 4'd3, 16, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        for (int k = 0; k < 14; k++) check($sformatf("t1_out[%0d]", k), 32'(obs_out[k]), 32'(exp1[k]));
        check("t1_done_cycle", 32'(first_done(16)), 32'd13);
        s = 0;
        for (int k = 0; k < 16; k++) s += obs_busy[k] ? 1 : 0;
        check("t1_busy_cycles", 32'(s), 32'd13);

        // Weight-buffer backpressure 1,0,0,1,1 across the LOAD cycles.
        run_tile(4'd3, 4'd0, 14, 32'h1, 32'h64, 32'h0, 32'h0);
        check("t2_out[3]", 32'(obs_out[3]), 32'h02);
        check("t2_out[4]", 32'(obs_out[4]), 32'h00);
        check("t2_out[5]", 32'(obs_out[5]), 32'h00);
        check("t2_out[6]", 32'(obs_out[6]), 32'h02);
        check("t2_out[7]", 32'(obs_out[7]), 32'h02);
        for (int k = 2; k < 7; k++) check($sformatf("t2_wb_ready[%0d]", k), 32'(obs_wbr[k]), 32'h1);
        check("t2_load_w_count", 32'(count_cmd(8'h02, 14, 1'b0)), 32'd3);
        check("t2_done_cycle", 32'(first_done(14)), 32'd11);

        // Zero lengths.
        run_tile(4'd0, 4'd0, 10, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        check("t3_out[1]", 32'(obs_out[1]), 32'h01);
        check("t3_out[3]", 32'(obs_out[3]), 32'h08);
        s = 0;
        for (int k = 0; k < 10; k++) s += (obs_wbr[k] || obs_actr[k]) ? 1 : 0;
        check("t3_ready_seen", 32'(s), 32'd0);
        check("t3_done_cycle", 32'(first_done(10)), 32'd6);

        // Abort in the 4th COMPUTE cycle.
        run_tile(4'd2, 4'd10, 16, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h80);
        check("t4_act_ready_prev", 32'(obs_actr[6]), 32'h1);
        check("t4_act_ready_abort", 32'(obs_actr[7]), 32'h0);
        check("t4_out_clear", 32'(obs_out[8]), 32'h01);
        for (int k = 9; k < 12; k++) check($sformatf("t4_out[%0d]", k), 32'(obs_out[k]), 32'h00);
        check("t4_compute_count", 32'(count_cmd(8'h04, 16, 1'b0)), 32'd3);
        check("t4_done_cycle", 32'(first_done(16)), 32'd11);

        // Second start mid-LOAD is ignored.
        run_tile(4'd5, 4'd2, 16, 32'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        check("t5_load_w_count", 32'(count_cmd(8'h02, 16, 1'b0)), 32'd5);
        check("t5_compute_count", 32'(count_cmd(8'h04, 16, 1'b0)), 32'd2);
        check("t5_done_cycle", 32'(first_done(16)), 32'd13);

        // Reset asserted between edges mid-tile.
        st = 1'b1; l_len = 4'd8; c_len = 4'd8; wv = 1'b1; av = 1'b1;
        tick();
        st = 1'b0;
        repeat (4) tick();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("t5_reset_state_out", 32'(bus16.state_out), 32'h00);
        check("t5_reset_busy", 32'(bus16.busy), 32'h0);
        check("t5_reset_busy4", 32'(bus4.busy), 32'h0);
        tick();
        reset = 1'b0;
        s = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            s += bus16.done ? 1 : 0;
            tick();
        end
        check("t5_no_done_after_reset", 32'(s), 32'd0);

        // Maximum 4-bit length.
        run_tile(4'd15, 4'd2, 26, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        check("t6_load_w_count4", 32'(count_cmd(8'h02, 26, 1'b1)), 32'd15);
        check("t6_load_w_count16", 32'(count_cmd(8'h02, 26, 1'b0)), 32'd15);
        check("t6_first_compute4", 32'(obs4_out[18]), 32'h04);
        check("t6_compute_count4", 32'(count_cmd(8'h04, 26, 1'b1)), 32'd2);
        check("t6_done_cycle", 32'(first_done(26)), 32'd23);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            st = ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 9);
            l_len = (r == 0) ? 4'd0 : (r == 1) ? 4'd15 : 4'($urandom_range(1, 6));
            r = $urandom_range(0, 9);
            c_len = (r == 0) ? 4'd0 : (r == 1) ? 4'd15 : 4'($urandom_range(1, 6));
            wv = ($urandom_range(0, 3) != 0);
            av = ($urandom_range(0, 3) != 0);
            ab = ($urandom_range(0, 39) == 0);
            tick();
        end
        quiet(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
